// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm-clock control path.
//   btn_state_t          : button_event FSM states (IDLE, PRESSED, LONG_HELD)
//   BTN_LONG_TICKS_DEF   : default long-press threshold in ticks
//   BTN_REPEAT_TICKS_DEF : default auto-repeat period in ticks
//   max_int()            : helper used to size tick counters
// ---------------------------------------------------------------------------
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } btn_state_t;

    localparam int BTN_LONG_TICKS_DEF   = 1000;
    localparam int BTN_REPEAT_TICKS_DEF = 200;

    // Larger of two integers, used for counter sizing at elaboration time.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : alarm_pkg

// File: rtl/button_event_if.sv
// ---------------------------------------------------------------------------
// button_event_if
// Groups the button input level, timebase strobe and the event outputs.
//   btn_level, tick                               : into button_event
//   press_p, release_p, long_p, repeat_p, held    : out of button_event
// Modports:
//   slave  : used by button_event
//   master : used by the driver / consumer of the events
// ---------------------------------------------------------------------------
interface button_event_if;

    logic btn_level;
    logic tick;
    logic press_p;
    logic release_p;
    logic long_p;
    logic repeat_p;
    logic held;

    modport slave (
        input  btn_level,
        input  tick,
        output press_p,
        output release_p,
        output long_p,
        output repeat_p,
        output held
    );

    modport master (
        output btn_level,
        output tick,
        input  press_p,
        input  release_p,
        input  long_p,
        input  repeat_p,
        input  held
    );

endinterface : button_event_if

// File: rtl/rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect
// Rising-edge detector on a level synchronous to clk.
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   level_i : sampled level
//   rise_o  : level_i & ~prev (combinational from the registered history)
// Parameter RST_VAL sets the reset value of the history register; a value
// of 1 means a level already high at reset release is not seen as a rise.
// ---------------------------------------------------------------------------
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;

    // History register holding the previous sample of the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_o = level_i & ~prev_q;

endmodule : rise_detect

// File: rtl/button_event.sv
// ---------------------------------------------------------------------------
// button_event
// Turns a debounced button level into one-cycle press, release, long-press
// and (optionally) auto-repeat events. Thresholds count tick strobes.
// Ports:
//   clk            : system clock
//   rst            : asynchronous active-high reset
//   bus (slave)    : btn_level, tick in; press_p, release_p, long_p,
//                    repeat_p, held out (all outputs registered)
// Parameters:
//   LONG_TICKS     : ticks of hold before long_p (>= 2)
//   REPEAT_TICKS   : ticks between repeat_p pulses (>= 1)
// Configuration macro:
//   BTN_AUTO_REPEAT_EN : when defined, LONG_HELD emits repeat_p every
//                        REPEAT_TICKS ticks; otherwise repeat_p is 0 and
//                        LONG_HELD only waits for release.
// ---------------------------------------------------------------------------
module button_event
    import alarm_pkg::*;
#(
    parameter int LONG_TICKS   = BTN_LONG_TICKS_DEF,
    parameter int REPEAT_TICKS = BTN_REPEAT_TICKS_DEF
) (
    input  logic           clk,
    input  logic           rst,
    button_event_if.slave  bus
);

    localparam int CW = $clog2(max_int(LONG_TICKS, REPEAT_TICKS));
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);
`endif

    btn_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          held_q, held_d;
    logic          rise_s;

    rise_detect #(
        .RST_VAL (1'b1)
    ) u_rise (
        .clk     (clk),
        .rst     (rst),
        .level_i (bus.btn_level),
        .rise_o  (rise_s)
    );

    // Next-state, counter and event-pulse decode. Release is checked before
    // the tick threshold so a release always wins over long/repeat.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = {CW{1'b0}};
                if (rise_s) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESSED: begin
                if (!bus.btn_level) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = {CW{1'b0}};
                end else if (bus.tick) begin
                    if (cnt_q == LONG_LAST) begin
                        state_d = LONG_HELD;
                        long_d  = 1'b1;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            LONG_HELD: begin
                if (!bus.btn_level) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = {CW{1'b0}};
                end else begin
`ifdef BTN_AUTO_REPEAT_EN
                    if (bus.tick) begin
                        if (cnt_q == REPEAT_LAST) begin
                            repeat_d = 1'b1;
                            cnt_d    = {CW{1'b0}};
                        end else begin
                            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
`else
                    cnt_d = {CW{1'b0}};
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
        held_d = (state_d != IDLE);
    end

    // State, counter and registered event outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= {CW{1'b0}};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign bus.press_p   = press_q;
    assign bus.release_p = release_q;
    assign bus.long_p    = long_q;
    assign bus.repeat_p  = repeat_q;
    assign bus.held      = held_q;

endmodule : button_event

// File: doc/button_event.md
# button_event

Converts the debounced level of one push-button into discrete one-cycle user events for the alarm-clock control FSM. It sits directly downstream of the debouncer and upstream of the time/alarm setting logic. It reports press, release and long-press events, and can optionally report auto-repeat events while the button is held. All time thresholds are measured in `tick` strobes, typically 1 kHz, so the thresholds are independent of the clock frequency.

## Interface
Parameters:
- `LONG_TICKS`, default 1000: ticks of continuous hold before `long_p`; must be ≥ 2.
- `REPEAT_TICKS`, default 200: ticks between `repeat_p` pulses after the long press; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; everything is registered on posedge.
- `rst`  in  1  asynchronous, active-high reset. One clock domain, with asynchronous active-high reset (already decided).
- `btn_level`  in  1  debounced button level, synchronous to `clk`.
- `tick`  in  1  one-cycle timebase strobe; counters advance only when it is 1.
- `press_p`  out  1  one-cycle pulse on a new press.
- `release_p`  out  1  one-cycle pulse on release.
- `long_p`  out  1  one-cycle pulse when the hold reaches `LONG_TICKS`.
- `repeat_p`  out  1  one-cycle pulse every `REPEAT_TICKS` while in the long hold.
- `held`  out  1  high while the state is not IDLE.

## Operation
- States (`btn_state_t`):
  - IDLE: waiting for a press.
  - PRESSED: held, below the long-press threshold.
  - LONG_HELD: held past the long-press threshold.
- Internal registers:
  - `prev`: the previous value of `btn_level`. It resets to 1, so a button that is already high when reset is released does not produce a press. A low level must be seen first.
  - `cnt`: tick counter, width `$clog2(max(LONG_TICKS,REPEAT_TICKS))`. It is cleared on every state change.
- IDLE → PRESSED: when `btn_level=1` and `prev=0`. Assert `press_p`.
- PRESSED:
  - If `btn_level=0`: go to IDLE and assert `release_p`.
  - Otherwise, on each `tick`, increment `cnt`.
  - On the tick where `cnt==LONG_TICKS-1`: assert `long_p`, go to LONG_HELD, clear `cnt`.
- LONG_HELD:
  - If `btn_level=0`: go to IDLE and assert `release_p`.
  - Otherwise, on each `tick`, increment `cnt`.
  - On the tick where `cnt==REPEAT_TICKS-1`: assert `repeat_p` (only if the repeat feature is compiled in) and clear `cnt`.
- Priorities and simultaneous events:
  - Release beats a threshold tick in the same cycle: `release_p` only, no `long_p`/`repeat_p`.
  - At most one output pulse is asserted in any cycle.
- Counter bounds: `cnt` never exceeds its threshold minus 1. There is no wrap beyond the compare value.

## Timing
- All outputs are registered. Every output resets to 0, the state resets to IDLE, `cnt` to 0, `prev` to 1.
- `press_p` is high in the cycle immediately after the posedge that first samples `btn_level=1` with `prev=0`. Latency is 1 clk.
- `long_p` is high 1 clk after the posedge that samples the `LONG_TICKS`-th tick counted since the press.
- `release_p` is high 1 clk after the first posedge that samples `btn_level=0` while `held=1`.
- `held` rises together with `press_p` and falls together with `release_p`.
- Reset mid-hold:
  - Immediately returns to IDLE with all outputs 0.
  - No `release_p` is emitted.
  - No new `press_p` until `btn_level` has been seen low.
- `tick` held constantly at 1 is legal, in which case thresholds are measured in clk cycles.

## Configuration
- `BTN_AUTO_REPEAT_EN` defined: LONG_HELD emits `repeat_p` every `REPEAT_TICKS` ticks, as described under Operation.
- Not defined:
  - `repeat_p` is tied to 0.
  - In LONG_HELD, `cnt` stays at 0.
  - LONG_HELD only waits for release.
  - `REPEAT_TICKS` is ignored.

## Structure
- The shared package `alarm_pkg` holds:
  - the `btn_state_t` enum (IDLE, PRESSED, LONG_HELD);
  - `BTN_LONG_TICKS_DEF` = 1000;
  - `BTN_REPEAT_TICKS_DEF` = 200.
- One sub-module, `rise_detect`. It holds the `prev` register, with its reset value as a parameter, and outputs `rise = btn_level & ~prev`.
- The FSM and counter remain in `button_event`.

## Test plan
All scenarios use `LONG_TICKS=4`, `REPEAT_TICKS=2`, `tick=1` every cycle, and `BTN_AUTO_REPEAT_EN` defined unless stated otherwise.
1. Short press: `btn_level` high for 2 cycles, then low → `press_p` 1 cycle after the rise, `release_p` 1 cycle after the fall, no `long_p`, `held` high for 2 cycles.
2. Long hold: `btn_level` high for 12 cycles → `press_p`, then `long_p` 4 cycles later, then `repeat_p` every 2 cycles (3 pulses), then `release_p`.
3. Without `BTN_AUTO_REPEAT_EN`, same stimulus as scenario 2 → `press_p`, `long_p`, `release_p`; `repeat_p` stays 0.
4. Release on the threshold cycle: `btn_level` falls in the same cycle as the 4th tick → `release_p` only, no `long_p`.
5. Reset: `btn_level`=1 through reset and afterwards → no `press_p`. After `btn_level` goes 0 then 1 → `press_p`. Reset asserted in LONG_HELD → all outputs 0 immediately, no `release_p`.
6. Sparse tick: `tick` every 3rd cycle, hold for 15 cycles → `long_p` after the 4th tick (12 cycles after the press, ±1 cycle depending on tick phase).
